// File: rtl/axis_bram_slave_pp.sv
// AXI-stream to FFT BRAM loader: one frame of real samples, natural or bit-reversed order, optional ping-pong banks.
// Writes combinationally in the accepting cycle, so there is no added latency. Ready is held high for the whole frame (no backpressure).
module axis_bram_slave_pp #(
  parameter int FFT_SIZE_MAX = 4096,
  parameter int ADDR_WIDTH   = 12,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 48,
  parameter int IN_AXI_WIDTH = 16,
  parameter int PING_PONG    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      go,
  input  logic [3:0]                log2_size,
  input  logic                      bitrev_en,
  output logic                      busy,
  output logic                      done,
  output logic                      frame_err,
  output logic                      bank,
  output logic [ADDR_WIDTH-1:0]     s2mem_waddr,
  output logic                      s2mem_bank,
  output logic [DATA_WIDTH-1:0]     s2mem_wdata,
  output logic                      s2mem_we,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [IN_AXI_WIDTH-1:0]   s_tdata,
  input  logic [IN_AXI_WIDTH/8-1:0] s_tkeep
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [3:0] AW4 = 4'(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(FFT_SIZE_MAX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [3:0]              lg;
  logic                    bitrev_q;
  logic                    bank_q;
  logic                    done_q;
  logic                    err_q;
  logic                    had_frame;

  logic [3:0]              lg_in;
  logic [3:0]              shamt;
  logic [ADDR_WIDTH-1:0]   last_idx;
  logic [ADDR_WIDTH-1:0]   rev_full;
  logic                    beat;
  logic                    data_beat;
  logic                    final_beat;
  logic signed [HALF-1:0]  re;

  always_comb begin
    lg_in    = (log2_size == 4'd0 || log2_size > AW4) ? AW4 : log2_size;
    shamt    = AW4 - lg;
    last_idx = MAX_IDX >> shamt;
    // Reversing across the full width, then shifting down, reverses only the low lg bits.
    rev_full = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) rev_full[i] = cnt[ADDR_WIDTH-1-i];
  end

  assign s_tready   = (state != IDLE);
  assign beat       = s_tvalid & s_tready;
  assign data_beat  = beat && (state == WRITE) && (s_tkeep != '0);
  assign final_beat = (cnt == last_idx);

  assign re          = HALF'($signed(s_tdata[SAMPLE_WIDTH-1:0]));
  assign s2mem_wdata = {re, {HALF{1'b0}}};
  assign s2mem_waddr = bitrev_q ? (rev_full >> shamt) : cnt;
  assign s2mem_bank  = bank_q;
  assign s2mem_we    = data_beat;

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign frame_err = err_q;
  assign bank      = bank_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lg        <= AW4;
      bitrev_q  <= 1'b0;
      bank_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      had_frame <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            lg       <= lg_in;
            bitrev_q <= bitrev_en;
            cnt      <= '0;
            err_q    <= 1'b0;
            state    <= WRITE;
            if (PING_PONG != 0 && had_frame) bank_q <= ~bank_q;
          end
        end
        WRITE: begin
          if (data_beat) begin
            cnt <= cnt + 1'b1;
            if (s_tlast) begin
              state     <= IDLE;
              done_q    <= 1'b1;
              had_frame <= 1'b1;
              if (!final_beat) err_q <= 1'b1;
            end else if (final_beat) begin
              err_q <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (beat && s_tlast) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            had_frame <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bram_slave_pp.sv
// Randomised bench for axis_bram_slave_pp against a frame-level reference model.
module tb_axis_bram_slave_pp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [3:0]  log2_size = 4'd0;
  logic        bitrev_en = 1'b0;
  logic        busy, done, frame_err, bank;
  logic [11:0] s2mem_waddr;
  logic        s2mem_bank;
  logic [47:0] s2mem_wdata;
  logic        s2mem_we;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [15:0] s_tdata = 16'd0;
  logic [1:0]  s_tkeep = 2'd0;

  axis_bram_slave_pp dut (
    .clk(clk), .reset_n(reset_n), .go(go), .log2_size(log2_size), .bitrev_en(bitrev_en),
    .busy(busy), .done(done), .frame_err(frame_err), .bank(bank),
    .s2mem_waddr(s2mem_waddr), .s2mem_bank(s2mem_bank), .s2mem_wdata(s2mem_wdata),
    .s2mem_we(s2mem_we), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep)
  );

  always #5 clk = ~clk;

  typedef logic [60:0] wr_t;  // {bank, addr, data}
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [15:0] bq_dat[$];
  logic [1:0]  bq_keep[$];
  logic        bq_last[$];
  int          tests = 0;
  int          fails = 0;
  int          dcount = 0;
  logic        exp_bank = 1'b0;
  bit          completed = 0;
  logic        exp_err = 1'b0;

  always @(negedge clk) begin
    if (s2mem_we) got_q.push_back({s2mem_bank, s2mem_waddr, s2mem_wdata});
    if (done) dcount++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic clear_beats();
    bq_dat.delete(); bq_keep.delete(); bq_last.delete();
  endtask

  task automatic add_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
    bq_dat.push_back(d); bq_keep.push_back(k); bq_last.push_back(l);
  endtask

  // Reference: data beats fill addresses 0..N-1 in order; tlast or the N-th data beat ends writing.
  task automatic build_expected(input int lg, input bit br);
    int lg_eff, n, k;
    bit drain;
    logic [11:0] a;
    logic [15:0] d;
    lg_eff = (lg == 0 || lg > 12) ? 12 : lg;
    n = 1 << lg_eff;
    k = 0;
    drain = 0;
    exp_err = 1'b0;
    for (int i = 0; i < bq_dat.size(); i++) begin
      if (drain) begin
        if (bq_last[i]) break;
        continue;
      end
      if (bq_keep[i] == 2'd0) continue;
      a = 12'd0;
      if (br) begin
        for (int b = 0; b < lg_eff; b++)
          if (((k >> b) & 1) == 1) a = a | 12'(1 << (lg_eff - 1 - b));
      end else begin
        a = 12'(k);
      end
      d = bq_dat[i];
      exp_q.push_back({exp_bank, a, {{8{d[15]}}, d, 24'h0}});
      if (bq_last[i]) begin
        if (k != n - 1) exp_err = 1'b1;
        break;
      end
      if (k == n - 1) begin
        exp_err = 1'b1;
        drain = 1;
      end
      k++;
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic start_frame(input logic [3:0] lg, input logic br);
    if (completed) exp_bank = ~exp_bank;
    go = 1'b1; log2_size = lg; bitrev_en = br;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic drive_beats(input int gap_pct);
    for (int i = 0; i < bq_dat.size(); i++) begin
      if ($urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          s_tvalid = 1'b0; s_tdata = 16'($urandom); s_tlast = 1'($urandom); s_tkeep = 2'($urandom);
          @(posedge clk); #1;
        end
      end
      s_tvalid = 1'b1; s_tdata = bq_dat[i]; s_tkeep = bq_keep[i]; s_tlast = bq_last[i];
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_tvalid = 1'b1; s_tkeep = 2'b11; go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", frame_err); end
    tests++; if (bank !== 1'b0) begin fails++; $display("FAIL reset_bank: got %b want 0", bank); end
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    tests++; if (s2mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", s2mem_we); end
    s_tvalid = 1'b0; reset_n = 1'b1;
    exp_bank = 1'b0; completed = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_bitrev_4096();
    int fd;
    got_q.delete(); exp_q.delete(); dcount = 0;
    start_frame(4'd12, 1'b1);
    clear_beats();
    for (int i = 0; i < 4096; i++) add_beat(16'(i), 2'b11, i == 4095);
    build_expected(12, 1);
    drive_beats(0);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bitrev_done_now: got %b want 1", done); end
    repeat (2) @(posedge clk);
    #1;
    completed = 1;
    fd = first_diff();
    tests++; if (fd !== -1) begin fails++; $display("FAIL bitrev_writes: diff at %0d got %h want %h (n=%0d/%0d)", fd, got_q[fd], exp_q[fd], got_q.size(), exp_q.size()); end
    tests++; if (got_q.size() < 4 || got_q[1][59:48] !== 12'd2048 || got_q[2][59:48] !== 12'd1024 || got_q[3][59:48] !== 12'd3072) begin
      fails++; $display("FAIL bitrev_addr_seq: got_n=%0d want 2048,1024,3072", got_q.size()); end
    tests++; if (got_q.size() < 4 || got_q[3][47:0] !== 48'h000003_000000) begin fails++; $display("FAIL bitrev_beat3_data: got n=%0d want 000003000000", got_q.size()); end
    tests++; if (dcount !== 1) begin fails++; $display("FAIL bitrev_done_count: got %0d want 1", dcount); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL bitrev_err: got %b want 0", frame_err); end
    tests++; if (bank !== 1'b0) begin fails++; $display("FAIL bitrev_bank: got %b want 0", bank); end
  endtask

  task automatic test_natural_null();
    int fd;
    got_q.delete(); exp_q.delete(); dcount = 0;
    start_frame(4'd3, 1'b0);
    clear_beats();
    add_beat(16'h8000, 2'b11, 1'b0);
    add_beat(16'h7FFF, 2'b01, 1'b0);
    add_beat(16'($urandom), 2'b00, 1'b1);
    for (int i = 0; i < 6; i++) add_beat(16'($urandom), 2'($urandom_range(1, 3)), i == 5);
    build_expected(3, 0);
    drive_beats(40);
    repeat (2) @(posedge clk);
    #1;
    completed = 1;
    fd = first_diff();
    tests++; if (fd !== -1) begin fails++; $display("FAIL null_writes: diff at %0d got %h want %h (n=%0d/%0d)", fd, got_q[fd], exp_q[fd], got_q.size(), exp_q.size()); end
    tests++; if (got_q.size() !== 8) begin fails++; $display("FAIL null_write_count: got %0d want 8", got_q.size()); end
    tests++; if (got_q.size() < 8 || got_q[0][47:24] !== 24'hFF8000 || got_q[1][47:24] !== 24'h007FFF) begin
      fails++; $display("FAIL null_sign_ext: got n=%0d want FF8000,007FFF", got_q.size()); end
    tests++; if (got_q.size() < 8 || got_q[7][59:48] !== 12'd7 || got_q[0][60] !== 1'b1) begin
      fails++; $display("FAIL null_last_addr_bank: got n=%0d want addr7 bank1", got_q.size()); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL null_err: got %b want 0", frame_err); end
    tests++; if (dcount !== 1) begin fails++; $display("FAIL null_done_count: got %0d want 1", dcount); end
  endtask

  task automatic test_early_tlast();
    int fd;
    logic br;
    got_q.delete(); exp_q.delete(); dcount = 0;
    br = 1'($urandom);
    start_frame(4'd3, br);
    clear_beats();
    for (int i = 0; i < 5; i++) add_beat(16'($urandom), 2'b11, i == 4);
    build_expected(3, br);
    drive_beats(30);
    repeat (2) @(posedge clk);
    #1;
    completed = 1;
    fd = first_diff();
    tests++; if (fd !== -1) begin fails++; $display("FAIL early_writes: diff at %0d got %h want %h (n=%0d/%0d)", fd, got_q[fd], exp_q[fd], got_q.size(), exp_q.size()); end
    tests++; if (got_q.size() !== 5) begin fails++; $display("FAIL early_write_count: got %0d want 5", got_q.size()); end
    tests++; if (frame_err !== exp_err || frame_err !== 1'b1) begin fails++; $display("FAIL early_err: got %b want 1", frame_err); end
    tests++; if (dcount !== 1) begin fails++; $display("FAIL early_done_count: got %0d want 1", dcount); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL early_busy: got %b want 0", busy); end
  endtask

  task automatic test_drain();
    int fd;
    got_q.delete(); exp_q.delete(); dcount = 0;
    start_frame(4'd3, 1'b0);
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL drain_err_cleared_by_go: got %b want 0", frame_err); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL drain_busy: got %b want 1", busy); end
    clear_beats();
    for (int i = 0; i < 11; i++) add_beat(16'($urandom), (i == 8) ? 2'b00 : 2'b11, i == 10);
    build_expected(3, 0);
    drive_beats(30);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL drain_done_after_beat11: got %b want 1", done); end
    repeat (2) @(posedge clk);
    #1;
    completed = 1;
    fd = first_diff();
    tests++; if (fd !== -1) begin fails++; $display("FAIL drain_writes: diff at %0d got %h want %h (n=%0d/%0d)", fd, got_q[fd], exp_q[fd], got_q.size(), exp_q.size()); end
    tests++; if (got_q.size() !== 8) begin fails++; $display("FAIL drain_write_count: got %0d want 8", got_q.size()); end
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL drain_err: got %b want 1", frame_err); end
    tests++; if (dcount !== 1) begin fails++; $display("FAIL drain_done_count: got %0d want 1", dcount); end
  endtask

  task automatic test_back_to_back();
    int fd;
    logic br;
    logic [2:0] want_bank;
    want_bank = 3'b010;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_bank = 1'b0; completed = 0;
    got_q.delete(); exp_q.delete(); dcount = 0;
    for (int f = 0; f < 3; f++) begin
      br = 1'($urandom);
      start_frame(4'd4, br);
      clear_beats();
      for (int i = 0; i < 16; i++) add_beat(16'($urandom), 2'($urandom_range(1, 3)), i == 15);
      build_expected(4, br);
      drive_beats(0);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done_frame%0d: got %b want 1", f, done); end
      completed = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    fd = first_diff();
    tests++; if (fd !== -1) begin fails++; $display("FAIL b2b_writes: diff at %0d got %h want %h (n=%0d/%0d)", fd, got_q[fd], exp_q[fd], got_q.size(), exp_q.size()); end
    tests++; if (got_q.size() !== 48) begin fails++; $display("FAIL b2b_write_count: got %0d want 48", got_q.size()); end
    tests++; if (got_q.size() < 48 || {got_q[0][60], got_q[16][60], got_q[32][60]} !== want_bank) begin
      fails++; $display("FAIL b2b_bank_seq: got n=%0d want banks 0,1,0", got_q.size()); end
    tests++; if (dcount !== 3) begin fails++; $display("FAIL b2b_done_count: got %0d want 3", dcount); end
  endtask

  task automatic test_reset_midframe();
    int fd;
    got_q.delete(); exp_q.delete(); dcount = 0;
    start_frame(4'd12, 1'b0);
    tests++; if (bank !== 1'b1) begin fails++; $display("FAIL midrst_bank_before: got %b want 1", bank); end
    clear_beats();
    for (int i = 0; i < 100; i++) add_beat(16'($urandom), 2'b11, 1'b0);
    drive_beats(0);
    s_tvalid = 1'b1; s_tkeep = 2'b11; reset_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL midrst_tready: got %b want 0", s_tready); end
    tests++; if (bank !== 1'b0) begin fails++; $display("FAIL midrst_bank: got %b want 0", bank); end
    reset_n = 1'b1; s_tvalid = 1'b0;
    exp_bank = 1'b0; completed = 0;
    got_q.delete(); exp_q.delete(); dcount = 0;
    start_frame(4'd3, 1'b0);
    clear_beats();
    for (int i = 0; i < 8; i++) add_beat(16'($urandom), 2'b11, i == 7);
    build_expected(3, 0);
    drive_beats(20);
    repeat (2) @(posedge clk);
    #1;
    completed = 1;
    fd = first_diff();
    tests++; if (fd !== -1) begin fails++; $display("FAIL midrst_writes: diff at %0d got %h want %h (n=%0d/%0d)", fd, got_q[fd], exp_q[fd], got_q.size(), exp_q.size()); end
    tests++; if (got_q.size() < 1 || got_q[0][60:48] !== 13'd0) begin fails++; $display("FAIL midrst_restart_addr0: got n=%0d want bank0 addr0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_bitrev_4096();
    test_natural_null();
    test_early_tlast();
    test_drain();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_bram_slave_pp.md
Name: axis_bram_slave_pp

Overview:
- Generalised AXI-stream-to-BRAM loader that sits between the window stage and the FFT core.
- Writes one frame of real samples, packed as complex words with zero imaginary part, into FFT working memory.
- Frame length is selectable at run time (power of two up to FFT_SIZE_MAX); address order is natural or bit-reversed; memory is optionally ping-pong banked.
- Adds tkeep null-beat handling, tlast framing checks with resynchronisation, and a frame-done pulse.

Parameters:
- FFT_SIZE_MAX, 4096: largest frame; power of two.
- ADDR_WIDTH, 12: log2(FFT_SIZE_MAX).
- SAMPLE_WIDTH, 16: signed input sample width.
- DATA_WIDTH, 48: BRAM word width; real part in the upper half, imaginary in the lower half; DATA_WIDTH/2 >= SAMPLE_WIDTH.
- IN_AXI_WIDTH, 16: tdata width; >= SAMPLE_WIDTH.
- PING_PONG, 1: 1 = two banks alternated per frame; 0 = single bank.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- go  in  1  start one frame; sampled in IDLE only.
- log2_size  in  4  frame length exponent, 1..ADDR_WIDTH; latched on go.
- bitrev_en  in  1  1 = bit-reversed write order; latched on go.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- frame_err  out  1  sticky; cleared by go or reset.
- bank  out  1  bank being written / most recently written; always 0 when PING_PONG=0.
- s2mem_waddr  out  ADDR_WIDTH  BRAM address within the bank.
- s2mem_bank  out  1  bank select accompanying the write.
- s2mem_wdata  out  DATA_WIDTH  packed sample.
- s2mem_we  out  1  write strobe.
- s_tvalid  in  1  AXI-stream valid.
- s_tready  out  1  AXI-stream ready.
- s_tlast  in  1  AXI-stream last.
- s_tdata  in  IN_AXI_WIDTH  sample in bits [SAMPLE_WIDTH-1:0].
- s_tkeep  in  IN_AXI_WIDTH/8  byte qualifiers.

Behaviour:
- Reset (reset_n=0 at a clk edge), also mid-frame:
  - state=IDLE; counter=0; bank=0; frame_err=0; done=0; s_tready=0; s2mem_we=0.
  - Partial BRAM contents are abandoned.
- States: IDLE, WRITE, DRAIN.
- IDLE:
  - On go: latch log2_size (values 0 or >ADDR_WIDTH clamp to ADDR_WIDTH) and bitrev_en; clear counter and frame_err; go to WRITE.
  - When PING_PONG=1 and at least one frame has completed, bank toggles on go.
- WRITE:
  - s_tready=1.
  - Beat = s_tvalid & s_tready.
  - Null beat: beat with s_tkeep==0. Consumed, no write, counter held; its tlast is ignored.
  - Data beat: s2mem_we=1 combinationally in the same cycle; counter increments at the clock edge.
- Address:
  - N = 2^log2_size.
  - Natural order: waddr = counter.
  - Bit-reversed order: waddr = reverse of counter[log2_size-1:0] across log2_size bits, upper bits 0. Example: N=8, counter=1 -> waddr=4.
- Data packing:
  - wdata = {sign-extend(tdata[SAMPLE_WIDTH-1:0]) to DATA_WIDTH/2, DATA_WIDTH/2 zeros}.
  - s2mem_bank = bank.
- Final data beat (counter==N-1):
  - With tlast=1: go to IDLE; done=1 next cycle.
  - With tlast=0: set frame_err; go to DRAIN. The beat is still written.
- Early tlast (data beat, tlast=1, counter<N-1):
  - Beat is written; set frame_err; go to IDLE; done=1 next cycle.
  - Unwritten addresses keep stale data.
- DRAIN:
  - s_tready=1; s2mem_we=0; all beats discarded.
  - On any accepted beat with tlast=1 -> IDLE; done pulses next cycle.
- go outside IDLE is ignored.
- Throughput: one sample per clock, no bubbles.
- done:
  - Exactly one cycle, asserted in the first IDLE cycle.
  - go in that same cycle is accepted.
  - frame_err clears at that go's edge.

Test Plan:
- log2_size=12, bitrev_en=1, 4096 back-to-back beats, tdata=index, tlast on the 4096th beat:
  - -> waddr sequence 0,2048,1024,3072,...; beat 3 wdata = 0x000003_000000; done pulses once; frame_err=0; bank=0.
- log2_size=3, bitrev_en=0, samples 0x8000,0x7FFF,...; random tvalid gaps; tkeep=0 beat inserted at position 2:
  - -> addresses 0..7 in order; wdata[47:24] = 0xFF8000 then 0x007FFF; null beat produces no we.
- N=8, tlast on the 5th beat:
  - -> 5 writes (addr 0..4); frame_err=1; done pulses; next go clears frame_err.
- N=8, no tlast on beat 8; tlast on beat 11:
  - -> 8 writes; DRAIN swallows beats 9-11 with we=0; done after beat 11; frame_err=1.
- PING_PONG=1, three consecutive frames, go asserted in the done cycle:
  - -> s2mem_bank = 0,1,0; no dropped beats.
- reset_n low mid-frame at counter=100:
  - -> next cycle busy=0, s_tready=0, bank=0; subsequent go restarts at address 0.
